// File: rtl/morra_giocatori_pkg.sv
// Shared types for the Morra Cinese move generator: move/result codes, FSM states,
// and the move rotation / legal-move helpers.
package morra_pkg;

    typedef enum logic [1:0] {NESSUNA = 2'b00, SASSO = 2'b01, CARTA = 2'b10, FORBICE = 2'b11} mossa_t;
    typedef enum logic [1:0] {ES_NULLO = 2'b00, ES_PRIMO = 2'b01, ES_SECONDO = 2'b10, ES_PARI = 2'b11} esito_t;
    typedef enum logic [2:0] {S_IDLE, S_CONFIG, S_MOVE, S_WAIT, S_CHECK, S_DONE} stato_t;

    // Galois mask for x^8+x^6+x^5+x^4+1, right-shifting form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic mossa_t ruota(input mossa_t m);
        case (m)
            SASSO:   ruota = CARTA;
            CARTA:   ruota = FORBICE;
            default: ruota = SASSO;
        endcase
    endfunction

    // raw 00 is folded onto SASSO before the blocked comparison so the result is never NESSUNA
    function automatic mossa_t genera(input logic [1:0] raw, input logic blk_v, input mossa_t blk);
        mossa_t m;
        m = (raw == 2'b00) ? SASSO : mossa_t'(raw);
        if (blk_v && m == blk)
            m = ruota(m);
        return m;
    endfunction

endpackage

// File: rtl/morra_giocatori_if.sv
// Judge-side bus: the generator (master) drives INIZIA/PRIMO/SECONDO, the judge answers MANCHE/PARTITA.
interface morra_giocatori_if;
    logic       INIZIA;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    modport master (output INIZIA, PRIMO, SECONDO, input MANCHE, PARTITA);
    modport slave  (input INIZIA, PRIMO, SECONDO, output MANCHE, PARTITA);
endinterface

// File: rtl/morra_giocatori_lfsr.sv
// Galois LFSR move source; exposes only the two 2-bit fields used as raw moves.
module morra_lfsr #(
    parameter int              W         = 8,
    parameter logic [W-1:0]    TAPS      = 8'hB8,
    parameter logic [W-1:0]    SEED_DFLT = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         step,
    output logic [1:0]   raw1,
    output logic [1:0]   raw2
);
    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= SEED_DFLT;
        else if (load)
            q <= (seed == '0) ? SEED_DFLT : seed;
        else if (step)
            q <= {1'b0, q[W-1:1]} ^ (q[0] ? TAPS : {W{1'b0}});
    end

    assign raw1 = q[1:0];
    assign raw2 = q[5:4];
endmodule

// File: rtl/morra_giocatori.sv
// Two-player Morra move generator driving the judge bus, manche by manche, until PARTITA or MAX_MANCHE.
// Optional MORRA_INJECT_EN adds inject_i / inject_err_o for deliberate illegal-move injection.
module morra_giocatori
    import morra_pkg::*;
#(
    parameter int                LFSR_W     = 8,
    parameter int                MAX_MANCHE = 20,
    parameter logic [LFSR_W-1:0] SEED_DFLT  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [3:0]        cfg_i,
    input  logic [LFSR_W-1:0] seed_i,
    morra_giocatori_if.master judge,
`ifdef MORRA_INJECT_EN
    input  logic              inject_i,
    output logic              inject_err_o,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        vincitore_o,
    output logic              timeout_o,
    output logic [4:0]        manche_cnt_o
);
    stato_t     state;
    mossa_t     blk1, blk2, last1, last2, blk1_n, blk2_n, mv1, mv2;
    logic       blk1_v, blk2_v, blk1_vn, blk2_vn;
    esito_t     man_q;
    logic [1:0] par_q;
    logic [4:0] cnt_n;
    logic [1:0] raw1, raw2;
    logic       start_ok, lfsr_step, fine_par, fine_to;
`ifdef MORRA_INJECT_EN
    logic       inj, inj_q;
`endif

    morra_lfsr #(.W(LFSR_W), .TAPS(LFSR_TAPS), .SEED_DFLT(SEED_DFLT)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .load(start_ok), .seed(seed_i),
        .step(lfsr_step), .raw1(raw1), .raw2(raw2)
    );

    // Next pair is generated from the blocked state as updated by this CHECK
    always_comb begin
        start_ok = start_i && (state == S_IDLE || state == S_DONE);
        blk1_n   = blk1;
        blk2_n   = blk2;
        blk1_vn  = blk1_v;
        blk2_vn  = blk2_v;
        cnt_n    = manche_cnt_o;
        if (state == S_CHECK) begin
            case (man_q)
                ES_PRIMO:   begin blk1_n = last1; blk1_vn = 1'b1; blk2_vn = 1'b0; end
                ES_SECONDO: begin blk2_n = last2; blk2_vn = 1'b1; blk1_vn = 1'b0; end
                ES_PARI:    begin blk1_vn = 1'b0; blk2_vn = 1'b0; end
                default:    ;
            endcase
            if (man_q != ES_NULLO && manche_cnt_o != 5'd31)
                cnt_n = manche_cnt_o + 5'd1;
        end
        fine_par  = (par_q != 2'b00);
        fine_to   = (int'(cnt_n) >= MAX_MANCHE);
        lfsr_step = (state == S_CONFIG) || (state == S_CHECK && !fine_par && !fine_to);
        mv1       = genera(raw1, blk1_vn, blk1_n);
        mv2       = genera(raw2, blk2_vn, blk2_n);
`ifdef MORRA_INJECT_EN
        inj = inject_i && blk1_vn;
        if (inj)
            mv1 = blk1_n;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            judge.INIZIA   <= 1'b0;
            judge.PRIMO    <= 2'b00;
            judge.SECONDO  <= 2'b00;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            vincitore_o    <= 2'b00;
            timeout_o      <= 1'b0;
            manche_cnt_o   <= 5'd0;
            blk1           <= NESSUNA;
            blk2           <= NESSUNA;
            blk1_v         <= 1'b0;
            blk2_v         <= 1'b0;
            last1          <= NESSUNA;
            last2          <= NESSUNA;
            man_q          <= ES_NULLO;
            par_q          <= 2'b00;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state         <= S_CONFIG;
                        judge.INIZIA  <= 1'b1;
                        judge.PRIMO   <= cfg_i[3:2];
                        judge.SECONDO <= cfg_i[1:0];
                        busy_o        <= 1'b1;
                        timeout_o     <= 1'b0;
                        vincitore_o   <= 2'b00;
                        manche_cnt_o  <= 5'd0;
                        blk1_v        <= 1'b0;
                        blk2_v        <= 1'b0;
                        blk1          <= NESSUNA;
                        blk2          <= NESSUNA;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CONFIG: begin
                    state         <= S_MOVE;
                    judge.INIZIA  <= 1'b0;
                    judge.PRIMO   <= mv1;
                    judge.SECONDO <= mv2;
                    last1         <= mv1;
                    last2         <= mv2;
                end
                S_MOVE: begin
                    state         <= S_WAIT;
                    judge.PRIMO   <= 2'b00;
                    judge.SECONDO <= 2'b00;
                end
                S_WAIT: begin
                    // judge result for the pair is valid now; hold it for CHECK
                    state <= S_CHECK;
                    man_q <= esito_t'(judge.MANCHE);
                    par_q <= judge.PARTITA;
                end
                S_CHECK: begin
                    blk1         <= blk1_n;
                    blk2         <= blk2_n;
                    blk1_v       <= blk1_vn;
                    blk2_v       <= blk2_vn;
                    manche_cnt_o <= cnt_n;
                    if (fine_par || fine_to) begin
                        state       <= S_DONE;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        vincitore_o <= fine_par ? par_q : 2'b00;
                        timeout_o   <= !fine_par;
                    end else begin
                        state         <= S_MOVE;
                        judge.PRIMO   <= mv1;
                        judge.SECONDO <= mv2;
                        last1         <= mv1;
                        last2         <= mv2;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MORRA_INJECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q        <= 1'b0;
            inject_err_o <= 1'b0;
        end else begin
            if (lfsr_step)
                inj_q <= inj;
            if (state == S_CHECK && inj_q && man_q != ES_NULLO)
                inject_err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_morra_giocatori.sv
// Bench for morra_giocatori: a judge model plus a reference move model feeding pair/end scoreboards.
module tb_morra_giocatori;
    logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
    logic [3:0] cfg_i = 4'h0;
    logic [7:0] seed_i = 8'h00;
    logic       busy_o, done_o, timeout_o;
    logic [1:0] vincitore_o;
    logic [4:0] manche_cnt_o;
`ifdef MORRA_INJECT_EN
    logic       inj_err;
`endif

    morra_giocatori_if jif();

    morra_giocatori dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_i(cfg_i), .seed_i(seed_i),
        .judge(jif.master),
`ifdef MORRA_INJECT_EN
        .inject_i(1'b0), .inject_err_o(inj_err),
`endif
        .busy_o(busy_o), .done_o(done_o), .vincitore_o(vincitore_o),
        .timeout_o(timeout_o), .manche_cnt_o(manche_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] pair; logic [4:0] cnt;} exp_pair_t;
    typedef struct packed {logic [1:0] vinc; logic to; logic [4:0] cnt;} exp_end_t;

    exp_pair_t  pq[$];
    exp_end_t   eq[$];
    int         errs = 0, checks = 0;
    int         cyc = 0, last_cyc = 0, n_done = 0, n_start = 0, seen_start = 0;
    bit         first_pair = 1'b0;
    logic [3:0] cfg_exp = 4'h0;
    int         rej_cfg = 0, pat_cfg = 0;
    logic [1:0] pval_cfg = 2'b00;
    // reference model state, owned by the monitor
    logic [7:0] mlfsr = 8'h00;
    logic [1:0] mb1 = 2'b00, mb2 = 2'b00;
    bit         mb1v = 1'b0, mb2v = 1'b0;
    int         mcnt = 0, rej_n = 0, part_at = 0;
    logic [1:0] part_val = 2'b00, resp_m = 2'b00, resp_p = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[0], q[7], q[6] ^ q[0], q[5] ^ q[0], q[4] ^ q[0], q[3], q[2], q[1]};
    endfunction

    function automatic logic [1:0] mv(input logic [1:0] raw, input bit bv, input logic [1:0] b);
        logic [1:0] m;
        m = (raw == 2'b00) ? 2'b01 : raw;
        if (bv && m == b) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
        return m;
    endfunction

    // sasso(01) beats forbice(11), forbice beats carta(10), carta beats sasso
    function automatic logic [1:0] arbitro(input logic [1:0] a, input logic [1:0] b);
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b11 && b == 2'b10) || (a == 2'b10 && b == 2'b01))
            return 2'b01;
        return 2'b10;
    endfunction

    task automatic push_pair();
        exp_pair_t e;
        e.pair = {mv(mlfsr[1:0], mb1v, mb1), mv(mlfsr[5:4], mb2v, mb2)};
        e.cnt  = 5'(mcnt);
        pq.push_back(e);
        mlfsr = lfsr_next(mlfsr);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // registered judge: answer computed mid-MOVE, presented from the next edge (valid in WAIT)
    always @(posedge clk) begin
        jif.MANCHE  <= resp_m;
        jif.PARTITA <= resp_p;
    end

    always @(negedge clk) begin
        logic [1:0] p1, p2, m, p;
        exp_pair_t  e;
        exp_end_t   x;
        if (!rst_n) begin
            resp_m = 2'b00;
            resp_p = 2'b00;
            pq.delete();
            eq.delete();
        end else begin
            if (jif.INIZIA) begin
                chk("cfg_expected", 32'(n_start != seen_start), 1);
                chk("cfg", 32'({jif.PRIMO, jif.SECONDO}), 32'(cfg_exp));
                seen_start = n_start;
                mlfsr = (seed_i == 8'h00) ? 8'hA5 : seed_i;
                mb1v = 1'b0; mb2v = 1'b0; mcnt = 0;
                rej_n = rej_cfg; part_at = pat_cfg; part_val = pval_cfg;
                first_pair = 1'b1;
                pq.delete(); eq.delete();
                push_pair();
            end else if (jif.PRIMO != 2'b00 || jif.SECONDO != 2'b00) begin
                p1 = jif.PRIMO;
                p2 = jif.SECONDO;
                if (pq.size() == 0) chk("pair_unexp", 32'({p1, p2}), 0);
                else begin
                    e = pq.pop_front();
                    chk("pair", 32'({p1, p2}), 32'(e.pair));
                    chk("cnt", 32'(manche_cnt_o), 32'(e.cnt));
                end
                if (!first_pair) chk("gap", cyc - last_cyc, 3);
                first_pair = 1'b0;
                last_cyc = cyc;
                chk("busy", 32'(busy_o), 1);
                chk("p1_blocked", 32'(mb1v && p1 == mb1), 0);
                chk("p2_blocked", 32'(mb2v && p2 == mb2), 0);
                if (rej_n > 0) begin rej_n--; m = 2'b00; end
                else m = arbitro(p1, p2);
                if (m != 2'b00) mcnt++;
                p = (m != 2'b00 && mcnt == part_at) ? part_val : 2'b00;
                case (m)
                    2'b01: begin mb1 = p1; mb1v = 1'b1; mb2v = 1'b0; end
                    2'b10: begin mb2 = p2; mb2v = 1'b1; mb1v = 1'b0; end
                    2'b11: begin mb1v = 1'b0; mb2v = 1'b0; end
                    default: ;
                endcase
                resp_m = m;
                resp_p = p;
                if (p != 2'b00) begin
                    x.vinc = p; x.to = 1'b0; x.cnt = 5'(mcnt); eq.push_back(x);
                end else if (mcnt >= 20) begin
                    x.vinc = 2'b00; x.to = 1'b1; x.cnt = 5'(mcnt); eq.push_back(x);
                end else begin
                    push_pair();
                end
            end
            if (done_o) begin
                n_done++;
                if (eq.size() == 0) chk("done_unexp", 32'(done_o), 0);
                else begin
                    x = eq.pop_front();
                    chk("vincitore", 32'(vincitore_o), 32'(x.vinc));
                    chk("timeout", 32'(timeout_o), 32'(x.to));
                    chk("end_cnt", 32'(manche_cnt_o), 32'(x.cnt));
                    chk("end_busy", 32'(busy_o), 0);
                end
            end
        end
    end

    task automatic start_match(input logic [7:0] seed, input logic [3:0] cfg,
                               input int rej, input int pat, input logic [1:0] pval);
        @(posedge clk); #1;
        seed_i = seed; cfg_i = cfg; cfg_exp = cfg;
        rej_cfg = rej; pat_cfg = pat; pval_cfg = pval;
        n_start++;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0, k;
        n0 = n_done;
        k = 0;
        while (n_done == n0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_seen", 32'(n_done != n0), 1);
        @(negedge clk); #1;
        chk("done_pulse", 32'(done_o), 0);
    endtask

    initial begin
        int seen, k;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inizia", 32'(jif.INIZIA), 0);
        chk("rst_primo", 32'(jif.PRIMO), 0);
        chk("rst_secondo", 32'(jif.SECONDO), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_cnt", 32'(manche_cnt_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_vinc", 32'(vincitore_o), 0);
        rst_n = 1'b1;

        // two rejected pairs first, then PARTITA=10 on the 4th valid manche
        start_match(8'h3C, 4'b0100, 2, 4, 2'b10);
        wait_done(400);

        // default seed, no PARTITA: ends on the manche limit; a start pulse mid-match is ignored
        repeat (3) @(posedge clk);
        start_match(8'h00, 4'b1011, 1, 0, 2'b00);
        repeat (15) @(posedge clk);
        #1;
        seed_i = 8'h77; cfg_i = 4'b1111; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(400);
        chk("timeout_hold", 32'(timeout_o), 1);

        // third match aborted by reset in the middle of a MOVE cycle
        start_match(8'h5A, 4'b0000, 0, 0, 2'b00);
        chk("timeout_clr", 32'(timeout_o), 0);
        seen = 0;
        k = 0;
        while (seen < 3 && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (jif.PRIMO != 2'b00 || jif.SECONDO != 2'b00) seen++;
        end
        chk("abort_moves", 32'(seen), 3);
        rst_n = 1'b0;
        #1;
        chk("abort_inizia", 32'(jif.INIZIA), 0);
        chk("abort_primo", 32'(jif.PRIMO), 0);
        chk("abort_secondo", 32'(jif.SECONDO), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_cnt", 32'(manche_cnt_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
